// File: rtl/writeback_top.sv
// Writeback stage: retires cache/ALU results into the register file and sequences
// exception/IRET flush, drain and fetch redirect.
module writeback_top #(
  parameter logic [31:0] XCPT_VECTOR  = 32'h0000_2000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic        alu_we,
  input  logic        alu_xcpt_valid,
  input  logic        alu_iret,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic [31:0] alu_pc,
  input  logic [1:0]  alu_xcpt_type,
  input  logic [31:0] alu_xcpt_addr,
  input  logic        cache_valid,
  input  logic        cache_we,
  input  logic        cache_xcpt_valid,
  input  logic [4:0]  cache_rd,
  input  logic [31:0] cache_data,
  input  logic [31:0] cache_pc,
  input  logic [1:0]  cache_xcpt_type,
  input  logic [31:0] cache_xcpt_addr,
  output logic        alu_stall,
  output logic        writeEnRF,
  output logic [4:0]  destRF,
  output logic [31:0] writeValRF,
  output logic        xcpt_valid,
  output logic [31:0] rmPC,
  output logic [31:0] rmAddr,
  output logic [1:0]  xcpt_type,
  output logic        flush_pipeline,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // state    | meaning
  // RUN      | accepting results from cache and ALU stages
  // FLUSH    | one cycle, exception values presented, pipeline flushed
  // DRAIN    | DRAIN_CYCLES cycles of flush while the pipeline empties
  // REDIRECT | one cycle fetch redirect to handler or IRET target
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, REDIRECT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        is_iret;
  logic [31:0] target;

  logic c_x, a_x, a_i, c_wr, a_wr;

  // Cache is the older instruction, so its exception masks everything from the ALU.
  assign c_x  = cache_valid & cache_xcpt_valid;
  assign a_x  = alu_valid & alu_xcpt_valid & ~c_x;
  assign a_i  = alu_valid & alu_iret & ~alu_xcpt_valid & ~c_x;
  assign c_wr = cache_valid & cache_we & ~cache_xcpt_valid;
  assign a_wr = alu_valid & alu_we & ~alu_xcpt_valid & ~alu_iret & ~c_x & ~c_wr;

  assign alu_stall = reset & (state == RUN) & alu_valid & alu_we & ~alu_xcpt_valid & ~alu_iret
                     & cache_valid & cache_we & ~cache_xcpt_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      cnt            <= 4'd0;
      is_iret        <= 1'b0;
      target         <= 32'd0;
      writeEnRF      <= 1'b0;
      destRF         <= 5'd0;
      writeValRF     <= 32'd0;
      xcpt_valid     <= 1'b0;
      rmPC           <= 32'd0;
      rmAddr         <= 32'd0;
      xcpt_type      <= 2'd0;
      flush_pipeline <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      writeEnRF      <= 1'b0;
      xcpt_valid     <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        RUN: begin
          if (c_x) begin
            rmPC           <= cache_pc;
            rmAddr         <= cache_xcpt_addr;
            xcpt_type      <= cache_xcpt_type;
            xcpt_valid     <= 1'b1;
            is_iret        <= 1'b0;
            flush_pipeline <= 1'b1;
            state          <= FLUSH;
          end else begin
            if (c_wr) begin
              writeEnRF  <= 1'b1;
              destRF     <= cache_rd;
              writeValRF <= cache_data;
            end else if (a_wr) begin
              writeEnRF  <= 1'b1;
              destRF     <= alu_rd;
              writeValRF <= alu_data;
            end
            if (a_x) begin
              rmPC           <= alu_pc;
              rmAddr         <= alu_xcpt_addr;
              xcpt_type      <= alu_xcpt_type;
              xcpt_valid     <= 1'b1;
              is_iret        <= 1'b0;
              flush_pipeline <= 1'b1;
              state          <= FLUSH;
            end else if (a_i) begin
              target         <= alu_data;
              is_iret        <= 1'b1;
              flush_pipeline <= 1'b1;
              state          <= FLUSH;
            end
          end
        end
        FLUSH: begin
          cnt   <= 4'(DRAIN_CYCLES);
          state <= DRAIN;
        end
        DRAIN: begin
          if (cnt <= 4'd1) begin
            cnt            <= 4'd0;
            flush_pipeline <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= is_iret ? target : XCPT_VECTOR;
            state          <= REDIRECT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_top.sv
// Bench for writeback_top: directed vector table, hand-written flush/reset sequences,
// and random traffic against a timeline-based reference model.
module tb_writeback_top;
  localparam logic [31:0] VEC = 32'h0000_2000;
  localparam int D = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_we, alu_xcpt_valid, alu_iret;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data, alu_pc, alu_xcpt_addr;
  logic [1:0]  alu_xcpt_type;
  logic        cache_valid, cache_we, cache_xcpt_valid;
  logic [4:0]  cache_rd;
  logic [31:0] cache_data, cache_pc, cache_xcpt_addr;
  logic [1:0]  cache_xcpt_type;
  logic        alu_stall, writeEnRF, xcpt_valid, flush_pipeline, redirect_valid;
  logic [4:0]  destRF;
  logic [31:0] writeValRF, rmPC, rmAddr, redirect_pc;
  logic [1:0]  xcpt_type;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  writeback_top #(.XCPT_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_we(alu_we), .alu_xcpt_valid(alu_xcpt_valid), .alu_iret(alu_iret),
    .alu_rd(alu_rd), .alu_data(alu_data), .alu_pc(alu_pc), .alu_xcpt_type(alu_xcpt_type),
    .alu_xcpt_addr(alu_xcpt_addr),
    .cache_valid(cache_valid), .cache_we(cache_we), .cache_xcpt_valid(cache_xcpt_valid),
    .cache_rd(cache_rd), .cache_data(cache_data), .cache_pc(cache_pc),
    .cache_xcpt_type(cache_xcpt_type), .cache_xcpt_addr(cache_xcpt_addr),
    .alu_stall(alu_stall), .writeEnRF(writeEnRF), .destRF(destRF), .writeValRF(writeValRF),
    .xcpt_valid(xcpt_valid), .rmPC(rmPC), .rmAddr(rmAddr), .xcpt_type(xcpt_type),
    .flush_pipeline(flush_pipeline), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_we = 0; alu_xcpt_valid = 0; alu_iret = 0;
    alu_rd = 0; alu_data = 0; alu_pc = 0; alu_xcpt_type = 0; alu_xcpt_addr = 0;
    cache_valid = 0; cache_we = 0; cache_xcpt_valid = 0;
    cache_rd = 0; cache_data = 0; cache_pc = 0; cache_xcpt_type = 0; cache_xcpt_addr = 0;
  endtask

  task automatic post_edge();
    @(posedge clock); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " writeEnRF"}, 32'(writeEnRF), 0);
    chk({tag, " destRF"}, 32'(destRF), 0);
    chk({tag, " writeValRF"}, writeValRF, 0);
    chk({tag, " xcpt_valid"}, 32'(xcpt_valid), 0);
    chk({tag, " rmPC"}, rmPC, 0);
    chk({tag, " rmAddr"}, rmAddr, 0);
    chk({tag, " xcpt_type"}, 32'(xcpt_type), 0);
    chk({tag, " flush"}, 32'(flush_pipeline), 0);
    chk({tag, " redirect_valid"}, 32'(redirect_valid), 0);
    chk({tag, " redirect_pc"}, redirect_pc, 0);
    chk({tag, " alu_stall"}, 32'(alu_stall), 0);
  endtask

  // Post-exception timeline: cycle 1 = flush with exception pulse, 2..D+1 = drain flush,
  // D+2 = redirect, then back to accepting.
  task automatic chk_flush_seq(input string tag, input bit exc, input logic [31:0] rpc);
    for (int k = 2; k <= D + 1; k++) begin
      @(negedge clock);
      cache_valid = 1; cache_we = 1; cache_rd = 5'd30; cache_data = 32'hFFFF_0000;
      alu_valid = 1; alu_we = 1; alu_rd = 5'd29;
      #1 chk({tag, " stall while flushing"}, 32'(alu_stall), 0);
      post_edge();
      chk({tag, " flush in drain"}, 32'(flush_pipeline), 1);
      chk({tag, " no write in drain"}, 32'(writeEnRF), 0);
      chk({tag, " xcpt pulse ended"}, 32'(xcpt_valid), 0);
      chk({tag, " no early redirect"}, 32'(redirect_valid), 0);
    end
    @(negedge clock); idle();
    post_edge();
    chk({tag, " redirect_valid"}, 32'(redirect_valid), 1);
    chk({tag, " redirect_pc"}, redirect_pc, rpc);
    chk({tag, " flush off at redirect"}, 32'(flush_pipeline), 0);
    chk({tag, " no write at redirect"}, 32'(writeEnRF), 0);
    post_edge();
    chk({tag, " redirect pulse ended"}, 32'(redirect_valid), 0);
    chk({tag, " redirect_pc held"}, redirect_pc, rpc);
    if (exc) chk({tag, " exception flag"}, 32'(xcpt_valid), 0);
  endtask

  typedef struct {
    logic        cv, cwe;
    logic [4:0]  crd;
    logic [31:0] cd;
    logic        av, awe;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  // Reference model state
  int          since;
  bit          m_exc, m_we, m_xv, m_rv, m_flush;
  logic [31:0] m_tgt, m_rpc, m_pc, m_addr, m_data;
  logic [4:0]  m_rd;
  logic [1:0]  m_type;

  function automatic bit model_stall();
    return since == 0 && alu_valid && alu_we && !alu_xcpt_valid && !alu_iret
           && cache_valid && cache_we && !cache_xcpt_valid;
  endfunction

  task automatic model_reset();
    since = 0; m_exc = 0; m_we = 0; m_xv = 0; m_rv = 0; m_flush = 0;
    m_tgt = 0; m_rpc = 0; m_pc = 0; m_addr = 0; m_data = 0; m_rd = 0; m_type = 0;
  endtask

  task automatic model_edge();
    m_we = 0; m_xv = 0; m_rv = 0;
    if (since == 0) begin
      if (cache_valid && cache_xcpt_valid) begin
        m_exc = 1; m_xv = 1; since = 1;
        m_pc = cache_pc; m_addr = cache_xcpt_addr; m_type = cache_xcpt_type;
      end else begin
        if (cache_valid && cache_we) begin
          m_we = 1; m_rd = cache_rd; m_data = cache_data;
        end else if (alu_valid && alu_we && !alu_xcpt_valid && !alu_iret) begin
          m_we = 1; m_rd = alu_rd; m_data = alu_data;
        end
        if (alu_valid && alu_xcpt_valid) begin
          m_exc = 1; m_xv = 1; since = 1;
          m_pc = alu_pc; m_addr = alu_xcpt_addr; m_type = alu_xcpt_type;
        end else if (alu_valid && alu_iret) begin
          m_exc = 0; m_tgt = alu_data; since = 1;
        end
      end
    end else begin
      since++;
      if (since == D + 2) begin
        m_rv = 1; m_rpc = m_exc ? VEC : m_tgt;
      end
      if (since == D + 3) since = 0;
    end
    m_flush = (since >= 1 && since <= D + 1);
  endtask

  task automatic model_compare();
    chk("rnd writeEnRF", 32'(writeEnRF), 32'(m_we));
    chk("rnd destRF", 32'(destRF), 32'(m_rd));
    chk("rnd writeValRF", writeValRF, m_data);
    chk("rnd xcpt_valid", 32'(xcpt_valid), 32'(m_xv));
    chk("rnd rmPC", rmPC, m_pc);
    chk("rnd rmAddr", rmAddr, m_addr);
    chk("rnd xcpt_type", 32'(xcpt_type), 32'(m_type));
    chk("rnd flush", 32'(flush_pipeline), 32'(m_flush));
    chk("rnd redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("rnd redirect_pc", redirect_pc, m_rpc);
  endtask

  initial begin
    vec_t vt[7];
    bit hold;
    vt[0] = '{0, 0, 5'd0, 32'h0, 1, 1, 5'd5, 32'hDEAD_BEEF, 1, 5'd5, 32'hDEAD_BEEF};
    vt[1] = '{1, 1, 5'd9, 32'h1234, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h1234};
    vt[2] = '{0, 0, 5'd0, 32'h0, 1, 0, 5'd6, 32'h55, 0, 5'd9, 32'h1234};
    vt[3] = '{1, 0, 5'd2, 32'h99, 1, 1, 5'd12, 32'hA5A5_A5A5, 1, 5'd12, 32'hA5A5_A5A5};
    vt[4] = '{1, 1, 5'd31, 32'hFFFF_FFFF, 1, 0, 5'd1, 32'h1, 1, 5'd31, 32'hFFFF_FFFF};
    vt[5] = '{0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd31, 32'hFFFF_FFFF};
    vt[6] = '{1, 1, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h0};

    // Reset with a stall-worthy input pattern: outputs and stall must be 0.
    idle();
    reset = 0;
    cache_valid = 1; cache_we = 1; alu_valid = 1; alu_we = 1;
    #12 chk_zero("reset");
    @(negedge clock); idle(); reset = 1;

    foreach (vt[i]) begin
      @(negedge clock);
      idle();
      cache_valid = vt[i].cv; cache_we = vt[i].cwe; cache_rd = vt[i].crd; cache_data = vt[i].cd;
      alu_valid = vt[i].av; alu_we = vt[i].awe; alu_rd = vt[i].ard; alu_data = vt[i].ad;
      #1 chk($sformatf("vec%0d alu_stall", i), 32'(alu_stall), 0);
      post_edge();
      chk($sformatf("vec%0d writeEnRF", i), 32'(writeEnRF), 32'(vt[i].e_we));
      chk($sformatf("vec%0d destRF", i), 32'(destRF), 32'(vt[i].e_rd));
      chk($sformatf("vec%0d writeValRF", i), writeValRF, vt[i].e_data);
    end
    @(negedge clock); idle();
    post_edge();
    chk("pulse writeEnRF", 32'(writeEnRF), 0);

    // Both stages writing: cache first, ALU held one cycle.
    @(negedge clock);
    cache_valid = 1; cache_we = 1; cache_rd = 5'd3; cache_data = 32'h11;
    alu_valid = 1; alu_we = 1; alu_rd = 5'd4; alu_data = 32'h22;
    #1 chk("dual stall", 32'(alu_stall), 1);
    post_edge();
    chk("dual first we", 32'(writeEnRF), 1);
    chk("dual first rd", 32'(destRF), 3);
    chk("dual first data", writeValRF, 32'h11);
    @(negedge clock);
    cache_valid = 0; cache_we = 0;
    #1 chk("dual stall released", 32'(alu_stall), 0);
    post_edge();
    chk("dual second we", 32'(writeEnRF), 1);
    chk("dual second rd", 32'(destRF), 4);
    chk("dual second data", writeValRF, 32'h22);
    @(negedge clock); idle();
    post_edge();
    chk("dual done we", 32'(writeEnRF), 0);

    // Cache exception alongside ALU exception and write: cache wins, nothing written.
    @(negedge clock);
    cache_valid = 1; cache_xcpt_valid = 1; cache_pc = 32'h1000; cache_xcpt_addr = 32'hBAD0;
    cache_xcpt_type = 2'd2; cache_we = 1; cache_rd = 5'd8;
    alu_valid = 1; alu_we = 1; alu_rd = 5'd9; alu_xcpt_valid = 1; alu_pc = 32'h7777;
    alu_xcpt_addr = 32'h8888; alu_xcpt_type = 2'd1;
    #1 chk("cx stall", 32'(alu_stall), 0);
    post_edge();
    chk("cx writeEnRF", 32'(writeEnRF), 0);
    chk("cx xcpt_valid", 32'(xcpt_valid), 1);
    chk("cx rmPC", rmPC, 32'h1000);
    chk("cx rmAddr", rmAddr, 32'hBAD0);
    chk("cx xcpt_type", 32'(xcpt_type), 2);
    chk("cx flush", 32'(flush_pipeline), 1);
    chk_flush_seq("cx", 1, VEC);

    // ALU exception with an older cache write: cache written, ALU fields captured.
    @(negedge clock);
    idle();
    cache_valid = 1; cache_we = 1; cache_rd = 5'd10; cache_data = 32'hC0DE;
    alu_valid = 1; alu_we = 1; alu_rd = 5'd11; alu_xcpt_valid = 1; alu_pc = 32'h3000;
    alu_xcpt_addr = 32'h4444; alu_xcpt_type = 2'd3;
    #1 chk("ax stall", 32'(alu_stall), 0);
    post_edge();
    chk("ax writeEnRF", 32'(writeEnRF), 1);
    chk("ax destRF", 32'(destRF), 10);
    chk("ax writeValRF", writeValRF, 32'hC0DE);
    chk("ax xcpt_valid", 32'(xcpt_valid), 1);
    chk("ax rmPC", rmPC, 32'h3000);
    chk("ax rmAddr", rmAddr, 32'h4444);
    chk("ax xcpt_type", 32'(xcpt_type), 3);
    chk_flush_seq("ax", 1, VEC);

    // IRET with cache write: write happens, no exception pulse, redirect to target.
    @(negedge clock);
    idle();
    cache_valid = 1; cache_we = 1; cache_rd = 5'd7; cache_data = 32'h77;
    alu_valid = 1; alu_iret = 1; alu_data = 32'h0400;
    post_edge();
    chk("iret writeEnRF", 32'(writeEnRF), 1);
    chk("iret destRF", 32'(destRF), 7);
    chk("iret writeValRF", writeValRF, 32'h77);
    chk("iret xcpt_valid", 32'(xcpt_valid), 0);
    chk("iret rmPC held", rmPC, 32'h3000);
    chk("iret flush", 32'(flush_pipeline), 1);
    chk_flush_seq("iret", 0, 32'h0400);

    // Reset in the middle of drain abandons the exception.
    @(negedge clock);
    idle();
    cache_valid = 1; cache_xcpt_valid = 1; cache_pc = 32'h5000; cache_xcpt_addr = 32'h6;
    cache_xcpt_type = 2'd1;
    post_edge();
    @(negedge clock); idle();
    post_edge();
    post_edge();
    chk("rst pre flush", 32'(flush_pipeline), 1);
    #2;
    cache_valid = 1; cache_we = 1; alu_valid = 1; alu_we = 1;
    reset = 0;
    #1 chk_zero("mid-drain reset");
    @(negedge clock); idle(); reset = 1;
    for (int k = 0; k < D + 4; k++) begin
      post_edge();
      chk("post reset no redirect", 32'(redirect_valid), 0);
      chk("post reset no flush", 32'(flush_pipeline), 0);
    end
    @(negedge clock);
    alu_valid = 1; alu_we = 1; alu_rd = 5'd21; alu_data = 32'h1357_9BDF;
    post_edge();
    chk("post reset write we", 32'(writeEnRF), 1);
    chk("post reset write rd", 32'(destRF), 21);
    chk("post reset write data", writeValRF, 32'h1357_9BDF);

    // Random traffic against the reference model, from a fresh reset.
    @(negedge clock); idle(); reset = 0;
    #2 reset = 1;
    model_reset();
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (!hold) begin
        alu_valid = ($urandom % 4) != 0;
        alu_we = $urandom % 2;
        alu_xcpt_valid = ($urandom % 16) == 0;
        alu_iret = ($urandom % 16) == 0;
        alu_rd = 5'($urandom); alu_data = $urandom; alu_pc = $urandom;
        alu_xcpt_addr = $urandom; alu_xcpt_type = 2'($urandom);
      end
      cache_valid = ($urandom % 3) != 0;
      cache_we = $urandom % 2;
      cache_xcpt_valid = ($urandom % 16) == 0;
      cache_rd = 5'($urandom); cache_data = $urandom; cache_pc = $urandom;
      cache_xcpt_addr = $urandom; cache_xcpt_type = 2'($urandom);
      #1;
      hold = model_stall();
      chk("rnd alu_stall", 32'(alu_stall), 32'(hold));
      @(posedge clock);
      model_edge();
      #1 model_compare();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_top.md
WRITEBACK_TOP -- requirements
Module: writeback_top

Interface
REQ-001 SHALL have parameter XCPT_VECTOR, default 32'h0000_2000, exception handler PC driven on redirect.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles flush is held after an exception (range 1..15).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 alu_valid/alu_we/alu_xcpt_valid/alu_iret  in  1 each  ALU-stage result valid / writes RF / carries exception / is IRET.
REQ-006 alu_rd 5, alu_data 32, alu_pc 32, alu_xcpt_type 2, alu_xcpt_addr 32  in  ALU-stage result fields (alu_data holds the IRET target).
REQ-007 cache_valid/cache_we/cache_xcpt_valid  in  1 each; cache_rd 5, cache_data 32, cache_pc 32, cache_xcpt_type 2, cache_xcpt_addr 32  in  cache-stage result fields.
REQ-008 alu_stall  out  1  ALU stage must hold its result this cycle.
REQ-009 writeEnRF out 1, destRF out 5, writeValRF out 32  register-file write port.
REQ-010 xcpt_valid out 1, rmPC out 32, rmAddr out 32, xcpt_type out 2  exception values written to rm0/rm1/rm2.
REQ-011 flush_pipeline out 1; redirect_valid out 1; redirect_pc out 32  flush and fetch redirect.

Function
REQ-012 SHALL implement FSM states RUN, FLUSH, DRAIN, REDIRECT; only RUN accepts inputs.
REQ-013 Cache stage is older than ALU stage; when both hold results, cache SHALL be processed first.
REQ-014 At most one RF write per cycle; RF outputs registered: input accepted in cycle N -> writeEnRF/destRF/writeValRF in N+1 for exactly one cycle.
REQ-015 alu_stall SHALL equal state==RUN & alu_valid & alu_we & !alu_xcpt_valid & !alu_iret & cache_valid & cache_we & !cache_xcpt_valid (combinational); ALU result consumed next cycle.
REQ-016 Valid result with we=0 and no exception/IRET SHALL be retired with no RF write.
REQ-017 cache_xcpt_valid in RUN: capture cache_pc, cache_xcpt_addr, cache_xcpt_type; discard ALU input that cycle; no RF write; go to FLUSH.
REQ-018 alu_xcpt_valid with no cache exception: write cache result if cache_we (cache valid), capture ALU exception fields, go to FLUSH; ALU writes no RF.
REQ-019 alu_iret (no exception on either input): cache result still written; latch alu_data as target; go to FLUSH with xcpt_valid not raised.
REQ-020 FLUSH (1 cycle): flush_pipeline=1; xcpt_valid=1 with rmPC/rmAddr/xcpt_type = captured values (exception only); next DRAIN.
REQ-021 DRAIN: flush_pipeline=1, 4-bit counter loaded with DRAIN_CYCLES, decrements each cycle; at count 1 -> REDIRECT; duration exactly DRAIN_CYCLES cycles.
REQ-022 REDIRECT (1 cycle): redirect_valid=1, redirect_pc=XCPT_VECTOR (exception) or latched target (IRET), flush_pipeline=0; next RUN.
REQ-023 In FLUSH/DRAIN/REDIRECT all inputs ignored, alu_stall=0, writeEnRF=0.
REQ-024 xcpt_valid, writeEnRF, redirect_valid SHALL be single-cycle pulses; outputs other than those pulses hold last value when not pulsing.
REQ-025 Exception on both inputs same cycle: cache exception wins; ALU exception dropped.

Reset
REQ-026 reset low SHALL immediately force state RUN, counter 0, all outputs 0 (alu_stall 0), regardless of FSM state.
REQ-027 Reset asserted mid-FLUSH/DRAIN SHALL abandon the exception; no redirect after release.
REQ-028 First input accepted on the first rising edge after reset deasserts.

Verification
REQ-029 alu_valid=1, alu_we=1, alu_rd=5, alu_data=32'hDEAD_BEEF, cache idle -> next cycle writeEnRF=1, destRF=5, writeValRF=32'hDEAD_BEEF, alu_stall=0.
REQ-030 Both valid with we: cache rd=3 data=32'h11, ALU rd=4 data=32'h22 -> alu_stall=1 cycle N; writes rd3 in N+1, rd4 in N+2.
REQ-031 cache_xcpt_valid=1, pc=32'h1000, addr=32'hBAD0, type=2 with ALU write valid -> no RF write; xcpt_valid pulse rmPC=32'h1000 rmAddr=32'hBAD0 xcpt_type=2; flush 1+3 cycles; redirect_pc=32'h2000.
REQ-032 alu_iret=1, alu_data=32'h0400 with cache write rd=7 -> rd7 written; xcpt_valid stays 0; redirect_pc=32'h0400 after 4 flush cycles.
REQ-033 reset low during DRAIN -> all outputs 0 at once; no redirect_valid after release; next write accepted normally.
